// File: rtl/bus_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_priority_select.sv
// Winner selection between inst and data requesters, with a streak counter that
// bounds how many contended grants in a row the data port may take.
module arb_priority_select
    import bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inst_req_i,
    input  logic data_req_i,
    input  logic grant_en_i,
    output logic win_inst_o,
    output logic win_data_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] streak_q, streak_d;
    logic             win_inst, win_data;

    always_comb begin
        win_inst = inst_req_i & (~data_req_i | (streak_q == LIMIT));
        win_data = data_req_i & ~win_inst;
        streak_d = streak_q;
        // Only data grants that actually made inst wait count toward the streak.
        if (grant_en_i) begin
            if (win_inst) begin
                streak_d = '0;
            end else if (win_data && inst_req_i && (streak_q != LIMIT)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign win_inst_o = win_inst;
    assign win_data_o = win_data;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between the core's inst and data ports: one
// outstanding access at a time, fully registered outputs, optional timeout.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_gnt_o,
    output logic              inst_rvalid_o,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_err_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic              data_sign_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              mem_sign_o,
    output logic [1:0]        mem_size_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, mem_sign_q, mem_sign_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              inst_gnt_q, inst_gnt_d, data_gnt_q, data_gnt_d;
    logic              inst_rvalid_q, inst_rvalid_d, data_rvalid_q, data_rvalid_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic              inst_err_q, inst_err_d, data_err_q, data_err_d;
    logic              win_inst, win_data, grant_en, timed_out, done;
    logic [DATA_W-1:0] rsp_data;

    assign grant_en  = (state_q == IDLE);
    assign timed_out = (TIMEOUT != 0) && (tmr_q == TMR_LAST);
    // A ready on the last allowed cycle still counts as a normal completion.
    assign done      = mem_ready_i || timed_out;
    assign rsp_data  = (mem_ready_i && !mem_we_q) ? mem_rdata_i : '0;

    arb_priority_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inst_req_i (inst_req_i),
        .data_req_i (data_req_i),
        .grant_en_i (grant_en),
        .win_inst_o (win_inst),
        .win_data_o (win_data)
    );

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_sign_d    = mem_sign_q;
        mem_size_d    = mem_size_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        inst_gnt_d    = 1'b0;
        data_gnt_d    = 1'b0;
        inst_rvalid_d = 1'b0;
        data_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata_q;
        data_rdata_d  = data_rdata_q;
        inst_err_d    = inst_err_q;
        data_err_d    = data_err_q;
        case (state_q)
            IDLE: begin
                if (win_inst) begin
                    state_d     = BUSY_I;
                    tmr_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_sign_d  = 1'b0;
                    mem_size_d  = SIZE_WORD;
                    mem_addr_d  = inst_addr_i;
                    mem_wdata_d = '0;
                    inst_gnt_d  = 1'b1;
                end else if (win_data) begin
                    state_d     = BUSY_D;
                    tmr_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we_i;
                    mem_sign_d  = data_sign_i;
                    mem_size_d  = data_size_i;
                    mem_addr_d  = data_addr_i;
                    mem_wdata_d = data_wdata_i;
                    data_gnt_d  = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        inst_rvalid_d = 1'b1;
                        inst_rdata_d  = rsp_data;
                        inst_err_d    = !mem_ready_i;
                    end else begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = rsp_data;
                        data_err_d    = !mem_ready_i;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_sign_q    <= 1'b0;
            mem_size_q    <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            inst_gnt_q    <= 1'b0;
            data_gnt_q    <= 1'b0;
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            inst_rdata_q  <= '0;
            data_rdata_q  <= '0;
            inst_err_q    <= 1'b0;
            data_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_sign_q    <= mem_sign_d;
            mem_size_q    <= mem_size_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            inst_gnt_q    <= inst_gnt_d;
            data_gnt_q    <= data_gnt_d;
            inst_rvalid_q <= inst_rvalid_d;
            data_rvalid_q <= data_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rdata_q  <= data_rdata_d;
            inst_err_q    <= inst_err_d;
            data_err_q    <= data_err_d;
        end
    end

    assign inst_gnt_o    = inst_gnt_q;
    assign inst_rvalid_o = inst_rvalid_q;
    assign inst_rdata_o  = inst_rdata_q;
    assign inst_err_o    = inst_err_q;
    assign data_gnt_o    = data_gnt_q;
    assign data_rvalid_o = data_rvalid_q;
    assign data_rdata_o  = data_rdata_q;
    assign data_err_o    = data_err_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_sign_o    = mem_sign_q;
    assign mem_size_o    = mem_size_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: random and directed requesters, a latency-programmable
// memory, a transaction-level reference model and a queue-based output monitor.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_req, data_req, data_we, data_sign;
    logic [1:0]    data_size;
    logic [AW-1:0] inst_addr, data_addr;
    logic [DW-1:0] data_wdata, mem_rdata;
    logic          mem_ready;
    logic          inst_gnt_o, inst_rvalid_o, inst_err_o, data_gnt_o, data_rvalid_o, data_err_o;
    logic [DW-1:0] inst_rdata_o, data_rdata_o, mem_wdata_o;
    logic          mem_req_o, mem_we_o, mem_sign_o, busy_o;
    logic [1:0]    mem_size_o;
    logic [AW-1:0] mem_addr_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt_o),
        .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o), .inst_err_o(inst_err_o),
        .data_req_i(data_req), .data_we_i(data_we), .data_sign_i(data_sign),
        .data_size_i(data_size), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_sign_o(mem_sign_o), .mem_size_o(mem_size_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .busy_o(busy_o)
    );

    typedef struct {
        bit        is_inst;
        bit        we;
        bit        sign;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        cyc;
    } gnt_t;

    typedef struct {
        bit        is_inst;
        bit [31:0] rdata;
        bit        err;
        int        cyc;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    // Reference model state (transaction level)
    bit        m_busy = 0, m_owner = 0, m_we = 0;
    int        m_cnt = 0, m_streak = 0;
    bit [31:0] m_addr = 0;
    bit        g_i = 0, g_d = 0;

    // Stimulus controls
    int prob_i = 0, prob_d = 0;
    bit hold_i = 0, hold_d = 0;
    int mem_mode = 3;   // 0 random latency, 1 never ready, 2 ready on last allowed cycle, 3 immediate

    // Monitor records
    int        last_gnt_cyc = 0, last_rv_cyc = 0, n_rv = 0, ord_n = 0;
    bit        rec = 0;
    logic [9:0]  ord = '0;
    logic [31:0] last_rdata = 0, last_addr = 0;
    logic        last_err = 0, last_rv_inst = 0, last_we = 0;
    logic [1:0]  last_size = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [31:0] mem_fn(logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // Memory: answers mem_req_o after a per-access wait chosen by mem_mode
    bit m_act = 0;
    int m_w = 0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                if (!m_act) begin
                    m_act = 1;
                    case (mem_mode)
                        0: m_w = ($urandom_range(9, 0) == 0) ? int'($urandom_range(9, 6)) : int'($urandom_range(2, 0));
                        2: m_w = TO - 1;
                        default: m_w = 0;
                    endcase
                end else if (m_w > 0) begin
                    m_w--;
                end
                mem_ready = (m_w == 0) && (mem_mode != 1);
                mem_rdata = mem_ready ? mem_fn(mem_addr_o) : $urandom;
            end else begin
                m_act = 0;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic model_step();
        gnt_t g;
        rsp_t r;
        bit   wi;
        if (!m_busy && (inst_req || data_req)) begin
            wi = inst_req && (!data_req || m_streak == SL);
            if (wi) m_streak = 0;
            else if (inst_req && m_streak < SL) m_streak++;
            g.is_inst = wi;
            g.cyc = cyc;
            if (wi) begin
                g.we = 0; g.sign = 0; g.size = 2'd2; g.addr = inst_addr; g.wdata = 0; g_i = 1;
            end else begin
                g.we = data_we; g.sign = data_sign; g.size = data_size;
                g.addr = data_addr; g.wdata = data_wdata; g_d = 1;
            end
            gq.push_back(g);
            m_busy = 1; m_cnt = 0; m_owner = wi; m_addr = g.addr; m_we = g.we;
        end else if (m_busy) begin
            m_cnt++;
            if (mem_ready || m_cnt == TO) begin
                r.is_inst = m_owner;
                r.err = !mem_ready;
                r.rdata = (mem_ready && !m_we) ? mem_fn(m_addr) : 32'h0;
                r.cyc = cyc;
                rq.push_back(r);
                m_busy = 0;
            end
        end
    endtask

    task automatic new_inst(logic [31:0] a);
        inst_req = 1'b1;
        inst_addr = a;
    endtask

    task automatic new_data(bit we, bit sg, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        data_req = 1'b1; data_we = we; data_sign = sg; data_size = sz; data_addr = a; data_wdata = wd;
    endtask

    task automatic rand_data();
        new_data(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)), $urandom, $urandom);
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (!rst) model_step();
        @(negedge clk);
        if (g_i) begin
            g_i = 0; inst_req = 1'b0;
            if (hold_i) new_inst($urandom & 32'hFFFF_FFFC);
        end
        if (g_d) begin
            g_d = 0; data_req = 1'b0;
            if (hold_d) rand_data();
        end
        if (!inst_req && int'($urandom_range(99, 0)) < prob_i) new_inst($urandom & 32'hFFFF_FFFC);
        if (!data_req && int'($urandom_range(99, 0)) < prob_d) rand_data();
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while ((inst_req || data_req || m_busy) && n < 300) begin
            cycle();
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL %s_idle: still busy after %0d cycles, expected idle", tag, n);
        end
        cycle();
        cycle();
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ctrl"}, 64'({inst_gnt_o, inst_rvalid_o, inst_err_o, data_gnt_o, data_rvalid_o,
                                 data_err_o, mem_req_o, mem_we_o, mem_sign_o, mem_size_o, busy_o}), 64'h0);
        chk({tag, "_inst_rdata"}, 64'(inst_rdata_o), 64'h0);
        chk({tag, "_data_rdata"}, 64'(data_rdata_o), 64'h0);
        chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'h0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'h0);
    endtask

    // Monitor: compares every DUT grant/response against the model's queues
    initial begin
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                checks++;
                $display("FAIL gnt_missing: got no grant pulse, expected grant in cycle %0d", gq[0].cyc);
                void'(gq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                checks++;
                $display("FAIL rsp_missing: got no rvalid pulse, expected rvalid in cycle %0d", rq[0].cyc);
                void'(rq.pop_front());
            end
            chk("busy", 64'(busy_o), 64'(m_busy));
            chk("mem_req", 64'(mem_req_o), 64'(m_busy));
            if (inst_gnt_o || data_gnt_o) begin
                chk("gnt_exclusive", 64'(inst_gnt_o & data_gnt_o), 64'h0);
                if (gq.size() == 0) begin
                    checks++;
                    $display("FAIL gnt_unexpected: inst_gnt=%0b data_gnt=%0b, expected none", inst_gnt_o, data_gnt_o);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
                    chk("gnt_port", 64'(inst_gnt_o), 64'(g.is_inst));
                    chk("mem_addr", 64'(mem_addr_o), 64'(g.addr));
                    chk("mem_we", 64'(mem_we_o), 64'(g.we));
                    chk("mem_size", 64'(mem_size_o), 64'(g.size));
                    chk("mem_sign", 64'(mem_sign_o), 64'(g.sign));
                    if (!g.is_inst) chk("mem_wdata", 64'(mem_wdata_o), 64'(g.wdata));
                end
                last_gnt_cyc = cyc; last_addr = mem_addr_o; last_we = mem_we_o; last_size = mem_size_o;
                if (rec && ord_n < 10) begin
                    ord = {ord[8:0], inst_gnt_o};
                    ord_n++;
                end
            end
            if (inst_rvalid_o || data_rvalid_o) begin
                chk("rvalid_exclusive", 64'(inst_rvalid_o & data_rvalid_o), 64'h0);
                if (rq.size() == 0) begin
                    checks++;
                    $display("FAIL rvalid_unexpected: inst_rvalid=%0b data_rvalid=%0b, expected none", inst_rvalid_o, data_rvalid_o);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
                    chk("rsp_port", 64'(inst_rvalid_o), 64'(r.is_inst));
                    chk("rsp_rdata", 64'(inst_rvalid_o ? inst_rdata_o : data_rdata_o), 64'(r.rdata));
                    chk("rsp_err", 64'(inst_rvalid_o ? inst_err_o : data_err_o), 64'(r.err));
                end
                n_rv++;
                last_rv_cyc = cyc;
                last_rv_inst = inst_rvalid_o;
                last_rdata = inst_rvalid_o ? inst_rdata_o : data_rdata_o;
                last_err = inst_rvalid_o ? inst_err_o : data_err_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int rv0;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_we = 0; data_sign = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        repeat (3) cycle();
        check_zero("por");
        rst = 1'b0;
        cycle();

        // Instruction fetch alone, memory answers in the first busy cycle
        mem_mode = 3;
        new_inst(32'h100);
        wait_idle("inst");
        chk("inst_latency", 64'(last_rv_cyc - last_gnt_cyc), 64'd1);
        chk("inst_rdata", 64'(last_rdata), 64'h13);
        chk("inst_err", 64'(last_err), 64'h0);
        chk("inst_port", 64'(last_rv_inst), 64'h1);

        // Byte write
        new_data(1'b1, 1'b0, 2'd0, 32'h2003, 32'hAB);
        wait_idle("write");
        chk("write_mem_we", 64'(last_we), 64'h1);
        chk("write_mem_size", 64'(last_size), 64'h0);
        chk("write_mem_addr", 64'(last_addr), 64'h2003);
        chk("write_rdata", 64'(last_rdata), 64'h0);
        chk("write_port", 64'(last_rv_inst), 64'h0);

        // Memory never answers
        mem_mode = 1;
        new_data(1'b0, 1'b0, 2'd2, 32'h3000, 32'h0);
        wait_idle("timeout");
        chk("timeout_latency", 64'(last_rv_cyc - last_gnt_cyc), 64'(TO));
        chk("timeout_err", 64'(last_err), 64'h1);
        chk("timeout_rdata", 64'(last_rdata), 64'h0);

        // Ready arrives on the final allowed busy cycle
        mem_mode = 2;
        new_data(1'b0, 1'b1, 2'd1, 32'h3004, 32'h0);
        wait_idle("edge_ready");
        chk("edge_ready_latency", 64'(last_rv_cyc - last_gnt_cyc), 64'(TO));
        chk("edge_ready_err", 64'(last_err), 64'h0);
        chk("edge_ready_rdata", 64'(last_rdata), 64'(mem_fn(32'h3004)));

        // Both ports requesting continuously
        mem_mode = 3;
        hold_i = 1; hold_d = 1; rec = 1; ord = '0; ord_n = 0;
        new_inst($urandom & 32'hFFFF_FFFC);
        rand_data();
        n = 0;
        while (ord_n < 10 && n < 200) begin
            cycle();
            n++;
        end
        chk("contention_order", 64'(ord), 64'(10'b0000100001));
        chk("contention_count", 64'(ord_n), 64'd10);
        hold_i = 0; hold_d = 0; rec = 0;
        wait_idle("contention");

        // Reset while a data access is outstanding
        mem_mode = 1;
        new_data(1'b0, 1'b0, 2'd2, 32'h4000, 32'h0);
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        m_busy = 0; m_streak = 0; g_i = 0; g_d = 0;
        inst_req = 0; data_req = 0;
        repeat (2) cycle();
        rst = 1'b0;
        rv0 = n_rv;
        repeat (12) cycle();
        chk("no_rvalid_after_rst", 64'(n_rv - rv0), 64'h0);
        mem_mode = 3;
        new_data(1'b0, 1'b0, 2'd2, 32'h4000, 32'h0);
        wait_idle("post_rst");
        chk("post_rst_rvalid", 64'(n_rv - rv0), 64'd1);
        chk("post_rst_rdata", 64'(last_rdata), 64'(mem_fn(32'h4000)));

        // Random traffic with random memory latency (including timeouts)
        mem_mode = 0;
        prob_i = 35; prob_d = 35;
        repeat (600) cycle();
        prob_i = 0; prob_d = 0;
        wait_idle("random");

        chk("gnt_queue_empty", 64'(gq.size()), 64'h0);
        chk("rsp_queue_empty", 64'(rq.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
